// File: rtl/ac97_frame_tx_if.sv
// -----------------------------------------------------------------------------
// ac97_frame_tx_if
//
// Purpose:
//   Groups the sound-controller side of the AC97 transmitter. It carries the
//   per-frame PCM sample pair with its strobe, and the register-write command
//   handshake.
//
// Signals:
//   I_LEFT_SAMPLE   [19:0]  PCM left, two's complement (slot 3)
//   I_RIGHT_SAMPLE  [19:0]  PCM right, two's complement (slot 4)
//   O_SAMPLE_STROBE         one-cycle pulse when the sample pair is latched
//   I_CMD_VALID             command write request
//   I_CMD_ADDR      [6:0]   codec register address
//   I_CMD_DATA      [15:0]  codec register write data
//   O_CMD_READY             command holding register empty
//
// Modports:
//   master : the sound controller (drives samples and commands)
//   slave  : the transmitter (ac97_frame_tx)
// -----------------------------------------------------------------------------
interface ac97_frame_tx_if;
    logic [19:0] I_LEFT_SAMPLE;
    logic [19:0] I_RIGHT_SAMPLE;
    logic        O_SAMPLE_STROBE;
    logic        I_CMD_VALID;
    logic [6:0]  I_CMD_ADDR;
    logic [15:0] I_CMD_DATA;
    logic        O_CMD_READY;

    modport master (
        output I_LEFT_SAMPLE,
        output I_RIGHT_SAMPLE,
        input  O_SAMPLE_STROBE,
        output I_CMD_VALID,
        output I_CMD_ADDR,
        output I_CMD_DATA,
        input  O_CMD_READY
    );

    modport slave (
        input  I_LEFT_SAMPLE,
        input  I_RIGHT_SAMPLE,
        output O_SAMPLE_STROBE,
        input  I_CMD_VALID,
        input  I_CMD_ADDR,
        input  I_CMD_DATA,
        output O_CMD_READY
    );
endinterface

// File: rtl/ac97_frame_tx.sv
// -----------------------------------------------------------------------------
// ac97_frame_tx
//
// Purpose:
//   Controller-to-codec end of an AC97 link. The codec bit clock is
//   oversampled on I_CLK (which must run at least 4x I_BITCLK). Every rising
//   edge of I_BITCLK advances a 256-bit frame: SYNC high for bits 0..15, then
//   MSB-first serial data carrying the tag slot, a command address/data pair
//   (slots 1/2) and 20-bit PCM left/right (slots 3/4). Bits 96..255 are zero.
//   The block also holds the codec in cold reset for RESET_HOLD cycles after
//   I_RESET, and accepts one pending register write through a valid/ready
//   holding register.
//
// Parameters:
//   RESET_HOLD   I_CLK cycles O_RESET_L stays low after I_RESET falls (>= 1)
//   SYNC_STAGES  synchronizer depth for I_BITCLK (>= 2)
//
// Ports:
//   I_CLK        system clock
//   I_RESET      synchronous active-high reset
//   I_BITCLK     AC97 bit clock from the codec, asynchronous to I_CLK
//   bus          ac97_frame_tx_if.slave: samples, strobe, command handshake
//   O_SYNC       AC97 SYNC
//   O_SDATA_OUT  AC97 serial data out
//   O_RESET_L    codec reset, active low
//
// Optional feature (compile-time macro AC97_INIT_SEQ_EN):
//   When defined, the first three frames after entering RUN carry built-in
//   writes (0x02<=0x0000, 0x18<=0x0808, 0x04<=0x0000) and O_CMD_READY stays
//   low until the third of those frames has started. When undefined, no init
//   writes are sent and O_CMD_READY is high from WAIT onward.
// -----------------------------------------------------------------------------
module ac97_frame_tx #(
    parameter int unsigned RESET_HOLD  = 1024,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           I_CLK,
    input  logic           I_RESET,
    input  logic           I_BITCLK,
    ac97_frame_tx_if.slave bus,
    output logic           O_SYNC,
    output logic           O_SDATA_OUT,
    output logic           O_RESET_L
);

    localparam int unsigned       HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_WAIT,
        ST_RUN
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  state_q;
    logic [HOLD_W-1:0]       hold_cnt_q;
    logic [SYNC_STAGES-1:0]  bclk_sync_q;
    logic                    bclk_hist_q;
    logic [7:0]              bit_cnt_q;

    logic                    sync_q;
    logic                    sdata_q;
    logic                    reset_l_q;
    logic                    strobe_q;
    logic                    cmd_ready_q;

    // Holding register: filled by the handshake, drained at frame start.
    logic                    hold_full_q;
    logic [6:0]              hold_addr_q;
    logic [15:0]             hold_data_q;

    // Frame registers: stable for the whole frame being shifted out.
    logic                    cmd_present_q;
    logic [6:0]              cmd_addr_q;
    logic [15:0]             cmd_data_q;
    logic [19:0]             left_q;
    logic [19:0]             right_q;

    // ------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------
    logic                    rise_evt;
    logic                    frame_start;
    logic                    cmd_accept;
    logic                    cmd_load;
    logic                    hold_full_d;
    logic                    init_done_d;
    logic                    cmd_ready_d;
    logic [95:0]             frame_vec;
    logic [6:0]              vec_idx;
    logic                    frame_bit;

    assign rise_evt    = bclk_sync_q[SYNC_STAGES-1] & ~bclk_hist_q;
    assign frame_start = (state_q == ST_RUN) && rise_evt && (bit_cnt_q == 8'd0);
    assign cmd_accept  = bus.I_CMD_VALID && cmd_ready_q;

`ifdef AC97_INIT_SEQ_EN
    logic [1:0] init_cnt_q;
    logic       init_load;

    // Built-in writes, indexed by how many have been sent so far.
    function automatic logic [22:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return {7'h02, 16'h0000};   // master volume
            2'd1:    return {7'h18, 16'h0808};   // PCM out volume
            default: return {7'h04, 16'h0000};   // headphone volume
        endcase
    endfunction

    assign init_load   = frame_start && (init_cnt_q != 2'd3);
    // Ready may rise once the third init frame has started.
    assign init_done_d = (init_cnt_q == 2'd3) || (init_load && (init_cnt_q == 2'd2));
    assign cmd_load    = frame_start && hold_full_q && !init_load;
`else
    assign init_done_d = 1'b1;
    assign cmd_load    = frame_start && hold_full_q;
`endif

    // NOTE: every signal gets a default before any branch, so this block stays purely combinational.
    always_comb begin
        hold_full_d = hold_full_q;
        if (cmd_accept) begin
            hold_full_d = 1'b1;
        end else if (cmd_load) begin
            hold_full_d = 1'b0;
        end
    end

    assign cmd_ready_d = init_done_d && !hold_full_d;

    // Outgoing frame content for bits 0..95, bit 0 at the MSB end.
    assign frame_vec = {
        1'b1, cmd_present_q, cmd_present_q, 2'b11, 11'd0,            // slot 0 tag
        cmd_present_q ? {1'b0, cmd_addr_q, 12'd0} : 20'd0,           // slot 1
        cmd_present_q ? {cmd_data_q, 4'd0}        : 20'd0,           // slot 2
        left_q,                                                      // slot 3
        right_q                                                      // slot 4
    };
    assign vec_idx = 7'd95 - bit_cnt_q[6:0];

    always_comb begin
        frame_bit = 1'b0;
        if (bit_cnt_q < 8'd96) begin
            frame_bit = frame_vec[vec_idx];
        end
    end

    // ------------------------------------------------------------------
    // I_BITCLK synchronizer and edge history
    // ------------------------------------------------------------------
    generate
        if (SYNC_STAGES > 1) begin : g_sync_chain
            always_ff @(posedge I_CLK) begin
                if (I_RESET) begin
                    bclk_sync_q <= '0;
                    bclk_hist_q <= 1'b0;
                end else begin
                    bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], I_BITCLK};
                    bclk_hist_q <= bclk_sync_q[SYNC_STAGES-1];
                end
            end
        end else begin : g_sync_single
            always_ff @(posedge I_CLK) begin
                if (I_RESET) begin
                    bclk_sync_q <= '0;
                    bclk_hist_q <= 1'b0;
                end else begin
                    bclk_sync_q <= I_BITCLK;
                    bclk_hist_q <= bclk_sync_q[0];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM with registered link outputs
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments only, so every register here sees the pre-edge value of every other.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            bit_cnt_q     <= 8'd0;
            sync_q        <= 1'b0;
            sdata_q       <= 1'b0;
            reset_l_q     <= 1'b0;
            strobe_q      <= 1'b0;
            cmd_ready_q   <= 1'b0;
            hold_full_q   <= 1'b0;
            cmd_present_q <= 1'b0;
            // NOTE: the datapath registers are cleared as well, so a frame after reset never leaks old samples or commands.
            hold_addr_q   <= 7'd0;
            hold_data_q   <= 16'd0;
            cmd_addr_q    <= 7'd0;
            cmd_data_q    <= 16'd0;
            left_q        <= 20'd0;
            right_q       <= 20'd0;
`ifdef AC97_INIT_SEQ_EN
            init_cnt_q    <= 2'd0;
`endif
        end else begin
            strobe_q    <= 1'b0;
            hold_full_q <= hold_full_d;
            if (cmd_accept) begin
                hold_addr_q <= bus.I_CMD_ADDR;
                hold_data_q <= bus.I_CMD_DATA;
            end

            unique case (state_q)
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q     <= ST_WAIT;
                        reset_l_q   <= 1'b1;
                        cmd_ready_q <= cmd_ready_d;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end

                ST_WAIT: begin
                    cmd_ready_q <= cmd_ready_d;
                    // This rise only aligns the counter; bit 0 goes out on the next one.
                    if (rise_evt) begin
                        state_q   <= ST_RUN;
                        bit_cnt_q <= 8'd0;
                    end
                end

                ST_RUN: begin
                    cmd_ready_q <= cmd_ready_d;
                    if (rise_evt) begin
                        sync_q    <= (bit_cnt_q < 8'd16);
                        sdata_q   <= frame_bit;
                        bit_cnt_q <= bit_cnt_q + 8'd1;     // 255 wraps to 0
                        if (bit_cnt_q == 8'd0) begin
                            left_q   <= bus.I_LEFT_SAMPLE;
                            right_q  <= bus.I_RIGHT_SAMPLE;
                            strobe_q <= 1'b1;
`ifdef AC97_INIT_SEQ_EN
                            if (init_load) begin
                                cmd_present_q            <= 1'b1;
                                {cmd_addr_q, cmd_data_q} <= init_cmd(init_cnt_q);
                                init_cnt_q               <= init_cnt_q + 2'd1;
                            end else
`endif
                            if (cmd_load) begin
                                cmd_present_q <= 1'b1;
                                cmd_addr_q    <= hold_addr_q;
                                cmd_data_q    <= hold_data_q;
                            end else begin
                                cmd_present_q <= 1'b0;
                            end
                        end
                    end
                end

                default: state_q <= ST_HOLD;
            endcase
        end
    end

    assign O_SYNC              = sync_q;
    assign O_SDATA_OUT         = sdata_q;
    assign O_RESET_L           = reset_l_q;
    assign bus.O_SAMPLE_STROBE = strobe_q;
    assign bus.O_CMD_READY     = cmd_ready_q;

endmodule
